// File: rtl/muldiv_ctrl_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_unit_pkg
// Description : Shared constants for the EX-stage ALU decoder and the RV32M
//               multiply/divide sequencer: ALU operation codes, funct7/funct3
//               encodings, ALUOp encodings, FSM state type and the
//               ALUOp/funct7/funct3 -> ALU operation decode function.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package muldiv_ctrl_unit_pkg;

    // ALU operation codes driven on o_alu_op
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SLT  = 4'b0011;
    localparam logic [3:0] ALU_SLTU = 4'b0100;
    localparam logic [3:0] ALU_XOR  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_OR   = 4'b1000;
    localparam logic [3:0] ALU_AND  = 4'b1001;

    // funct7 encodings
    localparam logic [6:0] FUNCT7_BASE   = 7'b0000000;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;
    localparam logic [6:0] FUNCT7_ALT    = 7'b0100000;

    // ALUOp encodings from the main control unit
    localparam logic [1:0] ALUOP_MEM   = 2'b00;
    localparam logic [1:0] ALUOP_ITYPE = 2'b10;
    localparam logic [1:0] ALUOP_RTYPE = 2'b11;

    // RV32M funct3 encodings
    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    // Sequencer FSM states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Base-ISA ALU decode. Anything not listed (including all M ops) is ADD.
    function automatic logic [3:0] alu_decode(
        input logic [1:0] alu_op,
        input logic [6:0] funct7,
        input logic [2:0] funct3
    );
        logic [3:0] op;
        op = ALU_ADD;
        case (alu_op)
            ALUOP_MEM: op = ALU_ADD;
            ALUOP_ITYPE: begin
                case (funct3)
                    3'b000:  op = ALU_ADD;
                    3'b001:  op = ALU_SLL;
                    3'b010:  op = ALU_SLT;
                    3'b011:  op = ALU_SLTU;
                    3'b100:  op = ALU_XOR;
                    3'b101: begin
                        if (funct7 == FUNCT7_BASE)     op = ALU_SRL;
                        else if (funct7 == FUNCT7_ALT) op = ALU_SRA;
                        else                           op = ALU_ADD;
                    end
                    3'b110:  op = ALU_OR;
                    default: op = ALU_AND;
                endcase
            end
            ALUOP_RTYPE: begin
                case ({funct7, funct3})
                    {FUNCT7_BASE, 3'b000}: op = ALU_ADD;
                    {FUNCT7_ALT,  3'b000}: op = ALU_SUB;
                    {FUNCT7_BASE, 3'b001}: op = ALU_SLL;
                    {FUNCT7_BASE, 3'b010}: op = ALU_SLT;
                    {FUNCT7_BASE, 3'b011}: op = ALU_SLTU;
                    {FUNCT7_BASE, 3'b100}: op = ALU_XOR;
                    {FUNCT7_BASE, 3'b101}: op = ALU_SRL;
                    {FUNCT7_ALT,  3'b101}: op = ALU_SRA;
                    {FUNCT7_BASE, 3'b110}: op = ALU_OR;
                    {FUNCT7_BASE, 3'b111}: op = ALU_AND;
                    default:               op = ALU_ADD;
                endcase
            end
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

endpackage
`default_nettype wire

// File: rtl/muldiv_ctrl_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_unit_if
// Description : EX-stage bundle between the pipeline and muldiv_ctrl_unit.
// Signals     : i_valid, i_flush, i_alu_op[1:0], i_funct7[6:0], i_funct3[2:0],
//               i_rs1/i_rs2[DATA_WIDTH-1:0]  (pipeline -> unit)
//               o_alu_op[3:0], o_stall, o_done, o_result[DATA_WIDTH-1:0]
//               (unit -> pipeline)
// Modports    : master = pipeline side, slave = muldiv_ctrl_unit side
// Revision    : 1.0 - initial release
// ============================================================================
interface muldiv_ctrl_unit_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  i_valid;
    logic                  i_flush;
    logic [1:0]            i_alu_op;
    logic [6:0]            i_funct7;
    logic [2:0]            i_funct3;
    logic [DATA_WIDTH-1:0] i_rs1;
    logic [DATA_WIDTH-1:0] i_rs2;
    logic [3:0]            o_alu_op;
    logic                  o_stall;
    logic                  o_done;
    logic [DATA_WIDTH-1:0] o_result;

    modport master (
        output i_valid, i_flush, i_alu_op, i_funct7, i_funct3, i_rs1, i_rs2,
        input  o_alu_op, o_stall, o_done, o_result
    );

    modport slave (
        input  i_valid, i_flush, i_alu_op, i_funct7, i_funct3, i_rs1, i_rs2,
        output o_alu_op, o_stall, o_done, o_result
    );
endinterface
`default_nettype wire

// File: rtl/muldiv_iter.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_iter
// Description : Unsigned iterative engine. Multiply is radix-2 shift-add,
//               divide is restoring shift-subtract; one step per i_step cycle,
//               DATA_WIDTH steps per operation.
// Ports       : i_clk, i_rst       clock / synchronous active-high reset
//               i_start            load operands and counter
//               i_is_div           operation select latched on i_start
//               i_a, i_b           multiplier/multiplicand or dividend/divisor
//               i_step             perform one iteration this cycle
//               o_done             this step is the final one
//               o_hi, o_lo         accumulator after this step
//                                  (mul: product {hi,lo}; div: rem=hi, quot=lo)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  wire logic                  i_clk,
    input  wire logic                  i_rst,
    input  wire logic                  i_start,
    input  wire logic                  i_is_div,
    input  wire logic [DATA_WIDTH-1:0] i_a,
    input  wire logic [DATA_WIDTH-1:0] i_b,
    input  wire logic                  i_step,
    output logic                       o_done,
    output logic [DATA_WIDTH-1:0]      o_hi,
    output logic [DATA_WIDTH-1:0]      o_lo
);
    localparam int              CNT_W    = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DATA_WIDTH - 1);

    logic                  is_div_q, is_div_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;

    logic [DATA_WIDTH:0]   w_mul_sum;
    logic [DATA_WIDTH:0]   w_rem_shift;
    logic                  w_div_ge;
    logic [DATA_WIDTH-1:0] w_div_diff;
    logic [DATA_WIDTH-1:0] w_step_hi;
    logic [DATA_WIDTH-1:0] w_step_lo;

    always_comb begin
        // Multiply: conditionally add the multiplicand to the high half, then
        // shift the {carry, hi, lo} chain right by one.
        w_mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
        // Divide: shift the next dividend bit into the partial remainder and
        // subtract the divisor if it fits. The remainder before the shift is
        // always below the divisor, so DATA_WIDTH+1 bits hold the shifted value
        // and the difference, when taken, fits in DATA_WIDTH bits.
        w_rem_shift = {hi_q, lo_q[DATA_WIDTH-1]};
        w_div_ge    = (w_rem_shift >= {1'b0, b_q});
        w_div_diff  = w_rem_shift[DATA_WIDTH-1:0] - b_q;

        if (is_div_q) begin
            w_step_hi = w_div_ge ? w_div_diff : w_rem_shift[DATA_WIDTH-1:0];
            w_step_lo = {lo_q[DATA_WIDTH-2:0], w_div_ge};
        end else begin
            w_step_hi = w_mul_sum[DATA_WIDTH:1];
            w_step_lo = {w_mul_sum[0], lo_q[DATA_WIDTH-1:1]};
        end
    end

    always_comb begin
        is_div_d = is_div_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        cnt_d    = cnt_q;
        if (i_start) begin
            is_div_d = i_is_div;
            hi_d     = '0;
            lo_d     = i_a;
            b_d      = i_b;
            cnt_d    = CNT_LOAD;
        end else if (i_step) begin
            hi_d = w_step_hi;
            lo_d = w_step_lo;
            if (cnt_q != '0) begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            is_div_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            b_q      <= '0;
            cnt_q    <= '0;
        end else begin
            is_div_q <= is_div_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            b_q      <= b_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_done = i_step & (cnt_q == '0);
    assign o_hi   = w_step_hi;
    assign o_lo   = w_step_lo;

endmodule
`default_nettype wire

// File: rtl/muldiv_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : muldiv_ctrl_unit
// Description : EX-stage ALU control decoder with RV32M sequencer. Decodes the
//               base-ISA ALU operation combinationally and runs
//               MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU on muldiv_iter,
//               stalling the pipeline while the engine iterates.
// Ports       : i_clk, i_rst  clock / synchronous active-high reset
//               bus           muldiv_ctrl_unit_if.slave (operands, decode
//                             fields, flush in; alu_op, stall, done, result out)
// Revision    : 1.0 - initial release
// ============================================================================
module muldiv_ctrl_unit
    import muldiv_ctrl_unit_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input wire logic            i_clk,
    input wire logic            i_rst,
    muldiv_ctrl_unit_if.slave   bus
);
    localparam logic [DATA_WIDTH-1:0] MOST_NEG = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    state_e                state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic                  neg_q, neg_d;
    logic [DATA_WIDTH-1:0] result_q, result_d;

    logic                  w_m_start;
    logic [2:0]            w_f3;
    logic                  w_a_signed, w_b_signed;
    logic                  w_neg_a, w_neg_b;
    logic [DATA_WIDTH-1:0] w_mag_a, w_mag_b;
    logic                  w_div_zero, w_overflow, w_special;
    logic [DATA_WIDTH-1:0] w_special_res;
    logic                  w_iter_start, w_iter_step, w_iter_done;
    logic [DATA_WIDTH-1:0] w_iter_hi, w_iter_lo;
    logic [2*DATA_WIDTH-1:0] w_prod_fix;
    logic [DATA_WIDTH-1:0] w_quot_fix, w_rem_fix;
    logic [DATA_WIDTH-1:0] w_final;

    assign w_f3      = bus.i_funct3;
    assign w_m_start = bus.i_valid & (bus.i_alu_op == ALUOP_RTYPE) &
                       (bus.i_funct7 == FUNCT7_MULDIV) & ~bus.i_flush &
                       (state_q == ST_IDLE);

    // Operand signedness and magnitudes. MUL is treated as unsigned: the low
    // half of the product is identical either way.
    always_comb begin
        w_a_signed = (w_f3 == F3_MULH) | (w_f3 == F3_MULHSU) |
                     (w_f3 == F3_DIV)  | (w_f3 == F3_REM);
        w_b_signed = (w_f3 == F3_MULH) | (w_f3 == F3_DIV) | (w_f3 == F3_REM);
        w_neg_a    = w_a_signed & bus.i_rs1[DATA_WIDTH-1];
        w_neg_b    = w_b_signed & bus.i_rs2[DATA_WIDTH-1];
        w_mag_a    = w_neg_a ? ('0 - bus.i_rs1) : bus.i_rs1;
        w_mag_b    = w_neg_b ? ('0 - bus.i_rs2) : bus.i_rs2;
    end

    // Division corner cases resolved without iterating
    always_comb begin
        w_div_zero = (bus.i_rs2 == '0);
        w_overflow = ((w_f3 == F3_DIV) | (w_f3 == F3_REM)) &
                     (bus.i_rs1 == MOST_NEG) & (bus.i_rs2 == '1);
        w_special  = w_f3[2] & (w_div_zero | w_overflow);
        if (w_div_zero) begin
            w_special_res = w_f3[1] ? bus.i_rs1 : '1;
        end else begin
            w_special_res = w_f3[1] ? '0 : bus.i_rs1;
        end
    end

    assign w_iter_start = w_m_start & ~w_special;
    assign w_iter_step  = (state_q == ST_BUSY) & ~bus.i_flush;

    muldiv_iter #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_iter (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (w_iter_start),
        .i_is_div (w_f3[2]),
        .i_a      (w_mag_a),
        .i_b      (w_mag_b),
        .i_step   (w_iter_step),
        .o_done   (w_iter_done),
        .o_hi     (w_iter_hi),
        .o_lo     (w_iter_lo)
    );

    // Sign fix-up applied once on the final engine output
    always_comb begin
        w_prod_fix = neg_q ? ('0 - {w_iter_hi, w_iter_lo}) : {w_iter_hi, w_iter_lo};
        w_quot_fix = neg_q ? ('0 - w_iter_lo) : w_iter_lo;
        w_rem_fix  = neg_q ? ('0 - w_iter_hi) : w_iter_hi;
        case (op_q)
            F3_MUL:                       w_final = w_prod_fix[DATA_WIDTH-1:0];
            F3_MULH, F3_MULHSU, F3_MULHU: w_final = w_prod_fix[2*DATA_WIDTH-1:DATA_WIDTH];
            F3_DIV, F3_DIVU:              w_final = w_quot_fix;
            F3_REM, F3_REMU:              w_final = w_rem_fix;
            default:                      w_final = w_quot_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        neg_d    = neg_q;
        result_d = result_q;
        case (state_q)
            ST_IDLE: begin
                if (w_m_start) begin
                    op_d  = w_f3;
                    // The remainder follows the dividend; product and
                    // quotient follow the XOR of the operand signs.
                    neg_d = (w_f3[2] & w_f3[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);
                    if (w_special) begin
                        result_d = w_special_res;
                        state_d  = ST_DONE;
                    end else begin
                        state_d  = ST_BUSY;
                    end
                end
            end
            ST_BUSY: begin
                if (bus.i_flush) begin
                    state_d = ST_IDLE;
                end else if (w_iter_done) begin
                    result_d = w_final;
                    state_d  = ST_DONE;
                end
            end
            // DONE never accepts: the instruction still in EX must not restart
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q  <= ST_IDLE;
            op_q     <= 3'b000;
            neg_q    <= 1'b0;
            result_q <= '0;
        end else begin
            state_q  <= state_d;
            op_q     <= op_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    assign bus.o_alu_op = alu_decode(bus.i_alu_op, bus.i_funct7, bus.i_funct3);
    assign bus.o_stall  = w_m_start | (state_q == ST_BUSY);
    assign bus.o_done   = (state_q == ST_DONE) & ~bus.i_flush;
    assign bus.o_result = result_q;

endmodule
`default_nettype wire

// File: tb/tb_muldiv_ctrl_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_muldiv_ctrl_unit
// Description : Self-checking bench for muldiv_ctrl_unit: ALU decode, RV32M
//               results and latency through a scoreboard, special cases,
//               flush and reset aborts.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_muldiv_ctrl_unit;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_ctrl_unit_if #(.DATA_WIDTH(W)) bus ();

    muldiv_ctrl_unit #(.DATA_WIDTH(W)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        logic [W-1:0] res;
        int           lat;
    } exp_t;

    exp_t         sb[$];
    int           checks   = 0;
    int           errors   = 0;
    logic [W-1:0] last_res = '0;

    task automatic idle_inputs();
        bus.i_valid  = 1'b0;
        bus.i_flush  = 1'b0;
        bus.i_alu_op = 2'b00;
        bus.i_funct7 = 7'h00;
        bus.i_funct3 = 3'b000;
        bus.i_rs1    = '0;
        bus.i_rs2    = '0;
    endtask

    task automatic drive_mop(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.i_valid  = 1'b1;
        bus.i_flush  = 1'b0;
        bus.i_alu_op = 2'b11;
        bus.i_funct7 = 7'b0000001;
        bus.i_funct3 = f3;
        bus.i_rs1    = a;
        bus.i_rs2    = b;
    endtask

    // Issues one M op, pushes its expectation, and follows it to o_done.
    task automatic run_mop(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] exp_res, input int lat);
        exp_t e;
        exp_t got;
        int   cyc;
        bit   seen;
        e.res = exp_res;
        e.lat = lat;
        sb.push_back(e);
        @(posedge clk); #1;
        drive_mop(f3, a, b);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc <= lat + 4) begin
            @(negedge clk);
            if (cyc == 0) begin
                checks++;
                if (bus.o_alu_op !== 4'b0000) begin
                    errors++;
                    $display("FAIL mop_alu_op f3=%b got=%b exp=0000", f3, bus.o_alu_op);
                end
            end
            checks++;
            if (bus.o_stall !== (cyc < lat)) begin
                errors++;
                $display("FAIL mop_stall f3=%b cyc=%0d got=%b exp=%b", f3, cyc, bus.o_stall, (cyc < lat));
            end
            if (bus.o_done === 1'b1) begin
                seen = 1'b1;
                checks++;
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL sb_empty f3=%b got=done exp=no_done", f3);
                end else begin
                    got = sb.pop_front();
                    last_res = got.res;
                    checks++;
                    if (bus.o_result !== got.res) begin
                        errors++;
                        $display("FAIL mop_result f3=%b got=%h exp=%h", f3, bus.o_result, got.res);
                    end
                    if (cyc !== got.lat) begin
                        errors++;
                        $display("FAIL mop_latency f3=%b got=%0d exp=%0d", f3, cyc, got.lat);
                    end
                end
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        if (!seen) begin
            checks++;
            errors++;
            $display("FAIL mop_timeout f3=%b got=no_done exp=done_at_%0d", f3, lat);
            sb.delete();
        end
    endtask

    task automatic end_ops();
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.o_stall !== 1'b0 || bus.o_done !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_op got=stall%b/done%b exp=stall0/done0", bus.o_stall, bus.o_done);
        end
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (bus.o_done !== 1'b0 || bus.o_stall !== 1'b0 || bus.o_result !== '0 || bus.o_alu_op !== 4'b0000) begin
            errors++;
            $display("FAIL reset_state got=done%b stall%b res%h alu%b exp=0/0/0/0000",
                     bus.o_done, bus.o_stall, bus.o_result, bus.o_alu_op);
        end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_alu_decode();
        // {alu_op[1:0], funct7[6:0], funct3[2:0], expected alu code[3:0]}
        logic [15:0] tbl [12];
        tbl = '{
            {2'b00, 7'h00, 3'b000, 4'b0000},
            {2'b10, 7'h00, 3'b101, 4'b0110},
            {2'b10, 7'h20, 3'b101, 4'b0111},
            {2'b10, 7'h00, 3'b010, 4'b0011},
            {2'b10, 7'h00, 3'b110, 4'b1000},
            {2'b10, 7'h00, 3'b100, 4'b0101},
            {2'b11, 7'h20, 3'b000, 4'b0001},
            {2'b11, 7'h00, 3'b011, 4'b0100},
            {2'b11, 7'h20, 3'b101, 4'b0111},
            {2'b11, 7'h00, 3'b001, 4'b0010},
            {2'b11, 7'h20, 3'b111, 4'b0000},
            {2'b01, 7'h00, 3'b111, 4'b0000}
        };
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            bus.i_valid  = 1'b1;
            bus.i_alu_op = tbl[i][15:14];
            bus.i_funct7 = tbl[i][13:7];
            bus.i_funct3 = tbl[i][6:4];
            @(negedge clk);
            checks++;
            if (bus.o_alu_op !== tbl[i][3:0] || bus.o_stall !== 1'b0) begin
                errors++;
                $display("FAIL alu_decode idx=%0d got=%b/stall%b exp=%b/stall0",
                         i, bus.o_alu_op, bus.o_stall, tbl[i][3:0]);
            end
        end
        // A SUB held in EX for several cycles never stalls
        @(posedge clk); #1;
        bus.i_alu_op = 2'b11;
        bus.i_funct7 = 7'h20;
        bus.i_funct3 = 3'b000;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_stall !== 1'b0 || bus.o_alu_op !== 4'b0001) begin
                errors++;
                $display("FAIL sub_no_stall cyc=%0d got=%b/stall%b exp=0001/stall0", i, bus.o_alu_op, bus.o_stall);
            end
        end
        end_ops();
    endtask

    task automatic test_mul();
        run_mop(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 33);
        end_ops();
    endtask

    task automatic test_mulh_back_to_back();
        run_mop(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33);
        run_mop(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 33);
        run_mop(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 33);
        end_ops();
    endtask

    task automatic test_div();
        run_mop(3'b100, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFA, 33);
        run_mop(3'b110, 32'hFFFF_FFEC, 32'd3, 32'hFFFF_FFFE, 33);
        run_mop(3'b101, 32'd100, 32'd7, 32'd14, 33);
        run_mop(3'b111, 32'd100, 32'd7, 32'd2, 33);
        end_ops();
    endtask

    task automatic test_special();
        run_mop(3'b101, 32'd13, 32'd0, 32'hFFFF_FFFF, 1);
        run_mop(3'b111, 32'd13, 32'd0, 32'd13, 1);
        run_mop(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
        run_mop(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1);
        end_ops();
    endtask

    task automatic test_flush();
        logic [W-1:0] held;
        logic [W-1:0] mul_exp;
        held = last_res;
        @(posedge clk); #1;
        drive_mop(3'b100, 32'd1000, 32'd7);
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc > 0) begin
                @(posedge clk); #1;
            end
            if (cyc == 10) bus.i_flush = 1'b1;
            @(negedge clk);
            checks++;
            if (bus.o_done !== 1'b0 || bus.o_stall !== 1'b1) begin
                errors++;
                $display("FAIL flush_pre cyc=%0d got=done%b/stall%b exp=done0/stall1", cyc, bus.o_done, bus.o_stall);
            end
        end
        @(posedge clk); #1;
        idle_inputs();
        @(negedge clk);
        checks++;
        if (bus.o_stall !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== held) begin
            errors++;
            $display("FAIL flush_abort got=stall%b/done%b/res%h exp=stall0/done0/res%h",
                     bus.o_stall, bus.o_done, bus.o_result, held);
        end
        mul_exp = 32'(12345 * 678);
        run_mop(3'b000, 32'd12345, 32'd678, mul_exp, 33);
        end_ops();
    endtask

    task automatic test_reset_midop();
        @(posedge clk); #1;
        drive_mop(3'b000, 32'd5, 32'd6);
        for (int cyc = 1; cyc <= 5; cyc++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        idle_inputs();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (bus.o_stall !== 1'b0 || bus.o_done !== 1'b0 || bus.o_result !== '0) begin
                errors++;
                $display("FAIL reset_abort cyc=%0d got=stall%b/done%b/res%h exp=stall0/done0/res0",
                         i, bus.o_stall, bus.o_done, bus.o_result);
            end
            @(posedge clk); #1;
        end
        last_res = '0;
        run_mop(3'b000, 32'd5, 32'd6, 32'd30, 33);
        end_ops();
    endtask

    initial begin
        test_reset();
        test_alu_decode();
        test_mul();
        test_mulh_back_to_back();
        test_div();
        test_flush();
        test_special();
        test_reset_midop();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_leftover got=%0d exp=0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
